rng_reaction_timer: RTL

- Consumer of the LFSR random source: samples a random delay in milliseconds, waits it out, lights the stimulus LED, then times the user's button response.
- Sits between the rng block (random_value input), the debounced/synchronised button, and the display/score logic (reaction_ms, result_valid).
- Detects early (false-start) presses and no-response timeouts.

---
 rtl/rng_game_pkg.sv | 13 +
 rtl/ms_prescaler.sv | 31 +++
 rtl/rng_reaction_timer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rng_game_pkg.sv
// Shared types and default timing constants for the reaction-game timers.
package rng_game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ARMED = 2'd2
    } state_e;

    localparam int DEF_CLKS_PER_MS = 50000;
    localparam int DEF_TIMEOUT_MS  = 9999;

endpackage

// File: rtl/ms_prescaler.sv
// Millisecond tick generator: one-cycle tick every CLKS_PER_MS clocks, restartable via clear.
module ms_prescaler
    import rng_game_pkg::*;
#(
    parameter int CLKS_PER_MS = DEF_CLKS_PER_MS
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_MS - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    // Free-running count that wraps on the terminal value or restarts on clear
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
        end else if (clear || tick) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/rng_reaction_timer.sv
// Reaction-time trial: random delay, stimulus LED, then time the button press
// (with false-start and no-response detection).
module rng_reaction_timer
    import rng_game_pkg::*;
#(
    parameter int CLKS_PER_MS = DEF_CLKS_PER_MS,
    parameter int DELAY_W     = 11,
    parameter int RT_W        = 14,
    parameter int TIMEOUT_MS  = DEF_TIMEOUT_MS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DELAY_W-1:0] random_value,
    input  logic               button,
    output logic               busy,
    output logic               led_on,
    output logic               result_valid,
    output logic               early,
    output logic               timeout,
    output logic [RT_W-1:0]    reaction_ms
);

    localparam logic [RT_W-1:0] TIMEOUT_RT   = RT_W'(TIMEOUT_MS);
    localparam logic [RT_W-1:0] TIMEOUT_LAST = RT_W'(TIMEOUT_MS - 1);

    state_e             state_q;
    logic [DELAY_W-1:0] delay_q;
    logic [RT_W-1:0]    rt_q;
    logic [RT_W-1:0]    reaction_q;
    logic               button_q;
    logic               busy_q;
    logic               led_q;
    logic               valid_q;
    logic               early_q;
    logic               timeout_q;

    logic tick;
    logic btn_rise;
    logic presc_clear;
    logic last_delay_tick;
    logic timeout_hit;

    ms_prescaler #(
        .CLKS_PER_MS(CLKS_PER_MS)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clear(presc_clear),
        .tick (tick)
    );

    // Edge detect and prescaler restart on entry to WAIT / ARMED
    always_comb begin
        btn_rise        = button & ~button_q;
        last_delay_tick = tick && (delay_q == DELAY_W'(1));
        // The window closes on the tick that would carry rt to TIMEOUT_MS
        timeout_hit     = (rt_q == TIMEOUT_RT) || (tick && (rt_q == TIMEOUT_LAST));
        case (state_q)
            IDLE:    presc_clear = start;
            WAIT:    presc_clear = last_delay_tick;
            default: presc_clear = 1'b0;
        endcase
    end

    // Trial sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            delay_q    <= {DELAY_W{1'b0}};
            rt_q       <= {RT_W{1'b0}};
            reaction_q <= {RT_W{1'b0}};
            button_q   <= 1'b0;
            busy_q     <= 1'b0;
            led_q      <= 1'b0;
            valid_q    <= 1'b0;
            early_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            button_q <= button;
            valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        delay_q   <= (random_value == {DELAY_W{1'b0}}) ? DELAY_W'(1) : random_value;
                        early_q   <= 1'b0;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= WAIT;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (btn_rise) begin
                        early_q    <= 1'b1;
                        reaction_q <= {RT_W{1'b0}};
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else if (tick) begin
                        delay_q <= delay_q - DELAY_W'(1);
                        if (last_delay_tick) begin
                            led_q   <= 1'b1;
                            rt_q    <= {RT_W{1'b0}};
                            state_q <= ARMED;
                        end else begin
                            state_q <= WAIT;
                        end
                    end else begin
                        state_q <= WAIT;
                    end
                end
                ARMED: begin
                    if (btn_rise) begin
                        reaction_q <= rt_q;
                        valid_q    <= 1'b1;
                        led_q      <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else if (timeout_hit) begin
                        rt_q       <= TIMEOUT_RT;
                        timeout_q  <= 1'b1;
                        reaction_q <= TIMEOUT_RT;
                        valid_q    <= 1'b1;
                        led_q      <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else if (tick) begin
                        rt_q <= rt_q + RT_W'(1);
                    end else begin
                        state_q <= ARMED;
                    end
                end
                default: begin
                    led_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign led_on       = led_q;
    assign result_valid = valid_q;
    assign early        = early_q;
    assign timeout      = timeout_q;
    assign reaction_ms  = reaction_q;

endmodule
